// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad entry path: key width, empty code, FSM states.
package keypad_pkg;
  localparam int KEY_W = 4;
  localparam logic [KEY_W-1:0] NO_KEY = '0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_PRESSED  = 3'd2,
    ST_REPEAT   = 3'd3,
    ST_RELEASE  = 3'd4
  } kstate_t;
endpackage

// File: rtl/key_event_fifo.sv
// Show-ahead event FIFO. Pointers carry one extra wrap bit so count = wr - rd.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module key_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr, rd;
  logic             do_push, do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign count   = wr - rd;
  assign empty   = (wr == rd);
  assign full    = (count == (AW+1)'(DEPTH));
  assign dout    = empty ? '0 : mem[rd[AW-1:0]];

  // pointer update; storage itself needs no reset since dout is masked when empty
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop)  rd <= rd + 1'b1;
    end
  end

  // entry storage
  always_ff @(posedge clock) begin
    if (do_push) mem[wr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/keypad_entry_controller.sv
// Debounce, typematic repeat and event buffering for the hex keypad scanner.
module keypad_entry_controller
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 50,
  parameter int REPEAT_RATE     = 10,
  parameter int FIFO_DEPTH      = 4,
  parameter int CNT_W           = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [KEY_W-1:0]            Code,
  input  logic                        Valid,
  input  logic                        enable,
  input  logic                        rd_en,
  input  logic                        clr_ovf,
  output logic [KEY_W-1:0]            key_code,
  output logic                        key_avail,
  output logic [$clog2(FIFO_DEPTH):0] key_count,
  output logic                        held,
  output logic                        overflow
);
  // compare against N-1 so the event fires in the Nth counted cycle
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_RATE - 1);
  localparam logic             DLY_ON   = (REPEAT_DELAY != 0);
  localparam logic             DEB_ONE  = (DEBOUNCE_CYCLES == 1);

  kstate_t          state;
  logic [CNT_W-1:0] cnt;
  logic [KEY_W-1:0] lat;
  logic             same;
  logic             push_evt;
  logic [KEY_W-1:0] evt_code;
  logic             fifo_full, fifo_empty, pop_eff, drop;

  assign same     = Valid & (Code == lat);
  assign evt_code = (state == ST_IDLE) ? Code : lat;
  assign pop_eff  = rd_en & ~fifo_empty;
  assign drop     = push_evt & fifo_full & ~pop_eff;
  assign key_avail = ~fifo_empty;

  // event strobe: fires in the same cycle the FSM takes the event transition
  always_comb begin
    push_evt = 1'b0;
    if (enable) begin
      case (state)
        ST_IDLE:     push_evt = Valid & DEB_ONE;
        ST_DEBOUNCE: push_evt = same & (cnt == DEB_LAST);
        ST_PRESSED:  push_evt = same & DLY_ON & (cnt == DLY_LAST);
        ST_REPEAT:   push_evt = same & (cnt == RPT_LAST);
        default:     push_evt = 1'b0;
      endcase
    end
  end

  // press/repeat/release sequencer; held is registered alongside the state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      lat   <= NO_KEY;
      held  <= 1'b0;
    end else if (!enable) begin
      state <= ST_IDLE;
      cnt   <= '0;
      held  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (Valid) begin
          lat <= Code;
          if (DEB_ONE) begin
            state <= ST_PRESSED;
            cnt   <= '0;
            held  <= 1'b1;
          end else begin
            state <= ST_DEBOUNCE;
            cnt   <= CNT_W'(1);
          end
        end
        ST_DEBOUNCE: begin
          if (!same) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state <= ST_PRESSED;
            cnt   <= '0;
            held  <= 1'b1;
          end else cnt <= cnt + 1'b1;
        end
        ST_PRESSED: begin
          if (!same) begin
            state <= ST_RELEASE;
            cnt   <= '0;
            held  <= 1'b0;
          end else if (DLY_ON) begin
            if (cnt == DLY_LAST) begin
              state <= ST_REPEAT;
              cnt   <= '0;
            end else cnt <= cnt + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (!same) begin
            state <= ST_RELEASE;
            cnt   <= '0;
            held  <= 1'b0;
          end else if (cnt == RPT_LAST) cnt <= '0;
          else cnt <= cnt + 1'b1;
        end
        ST_RELEASE: begin
          // any key activity restarts the release window; no direct rollover
          if (Valid) cnt <= '0;
          else if (cnt == DEB_LAST) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else cnt <= cnt + 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
          held  <= 1'b0;
        end
      endcase
    end
  end

  // sticky drop flag; a new drop outranks a clear in the same cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

  key_event_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(KEY_W)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_evt),
    .pop   (rd_en),
    .din   (evt_code),
    .dout  (key_code),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (key_count)
  );
endmodule

// File: tb/tb_keypad_entry_controller.sv
// Scoreboard bench: stimulus queues expected events, a negedge monitor checks every pop.
module tb_keypad_entry_controller;
  logic       clock, reset;
  logic [3:0] Code;
  logic       Valid, enable, rd_en, clr_ovf;
  logic [3:0] key_code;
  logic       key_avail, held, overflow;
  logic [2:0] key_count;

  int checks = 0, failures = 0;
  int edges = 0, base = 0;

  typedef struct { logic [3:0] code; int t; } exp_t;
  exp_t q[$];
  exp_t e;

  keypad_entry_controller dut (
    .clock(clock), .reset(reset), .Code(Code), .Valid(Valid), .enable(enable),
    .rd_en(rd_en), .clr_ovf(clr_ovf), .key_code(key_code), .key_avail(key_avail),
    .key_count(key_count), .held(held), .overflow(overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) edges++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic expect_ev(input logic [3:0] k, input int t);
    exp_t x;
    x.code = k;
    x.t    = t;
    q.push_back(x);
  endtask

  // press long enough for one event, then release back to idle
  task automatic press(input logic [3:0] k);
    Code = k; Valid = 1'b1; tick(4);
    Valid = 1'b0; tick(5);
  endtask

  // monitor: every accepted pop must match the scoreboard head
  always @(negedge clock) begin
    if (reset === 1'b1 && rd_en && key_avail) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pop actual=%0h required=none", key_code);
      end else begin
        e = q.pop_front();
        chk("pop_code", {28'd0, key_code}, {28'd0, e.code});
        if (e.t >= 0) chk("pop_time", edges - base, e.t);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; Code = 4'h0; Valid = 1'b0; enable = 1'b1; rd_en = 1'b0; clr_ovf = 1'b0;
    tick(2);
    chk("rst_avail", key_avail, 0);
    chk("rst_count", key_count, 0);
    chk("rst_code",  key_code, 0);
    chk("rst_held",  held, 0);
    chk("rst_ovf",   overflow, 0);
    reset = 1'b1;
    tick(1);

    // 1: short press rejected, four stable cycles accepted
    Code = 4'h5; Valid = 1'b1; tick(3);
    Valid = 1'b0; tick(1);
    chk("short_noevt", key_avail, 0);
    tick(1);
    Valid = 1'b1; base = edges;
    tick(3);
    chk("t1_pre_avail", key_avail, 0);
    tick(1);
    chk("t1_avail", key_avail, 1);
    chk("t1_code",  key_code, 4'h5);
    chk("t1_count", key_count, 1);
    chk("t1_held",  held, 1);
    expect_ev(4'h5, -1);
    Valid = 1'b0; tick(6);
    rd_en = 1'b1; tick(1); rd_en = 1'b0;
    chk("t1_drained", key_avail, 0);

    // 2: bounce pattern gives nothing; then one clean event
    Code = 4'h3;
    Valid = 1'b1; tick(1); Valid = 1'b0; tick(1);
    Valid = 1'b1; tick(2); Valid = 1'b0; tick(1);
    chk("bounce_noevt", key_avail, 0);
    Valid = 1'b1; tick(4);
    chk("t2_avail", key_avail, 1);
    chk("t2_code",  key_code, 4'h3);
    chk("t2_count", key_count, 1);
    expect_ev(4'h3, -1);
    Valid = 1'b0; tick(6);
    rd_en = 1'b1; tick(1); rd_en = 1'b0;

    // 3: typematic repeat with a draining consumer
    rd_en = 1'b1;
    Code = 4'hA; Valid = 1'b1; base = edges;
    expect_ev(4'hA, 4);  expect_ev(4'hA, 54); expect_ev(4'hA, 64);
    expect_ev(4'hA, 74); expect_ev(4'hA, 84); expect_ev(4'hA, 94);
    for (int i = 1; i <= 100; i++) begin
      tick(1);
      chk("t3_held", held, (i >= 4) ? 1 : 0);
    end
    Valid = 1'b0; tick(5);
    chk("t3_released", held, 0);
    rd_en = 1'b0;
    chk("t3_all_seen", q.size(), 0);

    // 4: overflow with five presses, then drain in order and clear
    for (int k = 1; k <= 5; k++) press(4'(k));
    expect_ev(4'h1, -1); expect_ev(4'h2, -1); expect_ev(4'h3, -1); expect_ev(4'h4, -1);
    chk("t4_count", key_count, 4);
    chk("t4_code",  key_code, 4'h1);
    chk("t4_ovf",   overflow, 1);
    rd_en = 1'b1; tick(4); rd_en = 1'b0;
    chk("t4_empty", key_avail, 0);
    chk("t4_ovf_sticky", overflow, 1);
    clr_ovf = 1'b1; tick(1); clr_ovf = 1'b0;
    chk("t4_ovf_clr", overflow, 0);

    // 5: full FIFO, push and pop on the same edge
    for (int k = 6; k <= 9; k++) press(4'(k));
    expect_ev(4'h6, -1); expect_ev(4'h7, -1); expect_ev(4'h8, -1); expect_ev(4'h9, -1);
    chk("t5_full", key_count, 4);
    Code = 4'hB; Valid = 1'b1; tick(3);
    rd_en = 1'b1; tick(1); rd_en = 1'b0;
    expect_ev(4'hB, -1);
    chk("t5_count", key_count, 4);
    chk("t5_ovf",   overflow, 0);
    chk("t5_head",  key_code, 4'h7);
    Valid = 1'b0; tick(5);
    rd_en = 1'b1; tick(4); rd_en = 1'b0;
    chk("t5_empty", key_avail, 0);

    // 6: async reset mid-repeat, recovery with key held, enable abort
    Code = 4'hC; Valid = 1'b1; tick(60);
    chk("t6_pre_held", held, 1);
    chk("t6_pre_count", key_count, 2);
    #3 reset = 1'b0;
    #1;
    chk("t6_rst_avail", key_avail, 0);
    chk("t6_rst_count", key_count, 0);
    chk("t6_rst_code",  key_code, 0);
    chk("t6_rst_held",  held, 0);
    chk("t6_rst_ovf",   overflow, 0);
    #1 reset = 1'b1;
    base = edges;
    expect_ev(4'hC, 4);
    rd_en = 1'b1; tick(5); rd_en = 1'b0;
    Valid = 1'b0; tick(6);

    Code = 4'hD; Valid = 1'b1; tick(2);
    enable = 1'b0; tick(1);
    chk("t6_en_held", held, 0);
    tick(3);
    Valid = 1'b0; tick(1);
    enable = 1'b1; tick(2);
    chk("t6_en_noevt", key_avail, 0);
    chk("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
